// File: rtl/wbutohex_pack_if.sv
// Byte-in / packed-word-out stream bundle between the serial receiver,
// the ASCII decoder/packer and the command decompressor.
interface wbutohex_pack_if #(
    parameter int unsigned DW = 6
);
    logic          i_stb;
    logic          o_busy;
    logic [7:0]    i_byte;
    logic          o_soft_reset;
    logic          o_stb;
    logic          i_busy;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic [7:0]    o_raw;
    logic [15:0]   o_drop;

    // The decoder/packer side.
    modport slave (
        input  i_stb, i_byte, i_busy,
        output o_busy, o_soft_reset, o_stb, o_valid, o_data, o_raw, o_drop
    );

    // The side that feeds bytes in and consumes words.
    modport master (
        output i_stb, i_byte, i_busy,
        input  o_busy, o_soft_reset, o_stb, o_valid, o_data, o_raw, o_drop
    );
endinterface

// File: rtl/wbutohex_pack.sv
// ASCII-to-symbol decoder and packer for the wbubus command path.
// MODE 0 decodes the 6-bit wbu alphabet, MODE 1 plain hex (4-bit);
// PACK symbols are shifted into one word, first symbol in the MS bits.
module wbutohex_pack #(
    parameter int unsigned MODE = 0,
    parameter int unsigned PACK = 1
) (
    input  logic           i_clk,
    input  logic           i_reset,
    wbutohex_pack_if.slave bus
);
    localparam int unsigned BW = (MODE == 0) ? 6 : 4;
    localparam int unsigned DW = PACK * BW;
    localparam int unsigned CW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(PACK - 1);

    logic [DW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_stb;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [7:0]    r_raw;
    logic [15:0]   r_drop;
    logic          r_soft_reset;

    logic [6:0]    w_b;
    logic [6:0]    w_sym7;
    logic          w_legal;
    logic          w_ctrl_c;
    logic          w_accept;
    logic [BW-1:0] w_sym;
    logic [DW-1:0] w_acc_next;

    // Decode the received byte into a symbol and a legality flag.
    always_comb begin
        w_b     = bus.i_byte[6:0];
        w_sym7  = 7'd0;
        w_legal = 1'b0;
        if (w_b >= 7'h30 && w_b <= 7'h39) begin
            w_sym7  = w_b - 7'h30;
            w_legal = 1'b1;
        end else if (MODE == 0) begin
            if (w_b >= 7'h41 && w_b <= 7'h5A) begin
                w_sym7  = w_b - 7'd55;
                w_legal = 1'b1;
            end else if (w_b >= 7'h61 && w_b <= 7'h7A) begin
                w_sym7  = w_b - 7'd61;
                w_legal = 1'b1;
            end else if (w_b == 7'h40) begin
                w_sym7  = 7'd62;
                w_legal = 1'b1;
            end else if (w_b == 7'h25) begin
                w_sym7  = 7'd63;
                w_legal = 1'b1;
            end
        end else begin
            if (w_b >= 7'h41 && w_b <= 7'h46) begin
                w_sym7  = w_b - 7'd55;
                w_legal = 1'b1;
            end else if (w_b >= 7'h61 && w_b <= 7'h66) begin
                w_sym7  = w_b - 7'd87;
                w_legal = 1'b1;
            end
        end
        if (bus.i_byte[7]) begin
            w_legal = 1'b0;
        end
    end

    assign w_sym      = BW'(w_sym7);
    assign w_acc_next = DW'({r_acc, w_sym});
    assign w_ctrl_c   = (w_b == 7'h03);
    assign w_accept   = bus.i_stb && !(r_stb && bus.i_busy);

    // Shift symbols in, emit words, report framing/illegal bytes and ^C.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_stb        <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_raw        <= 8'd0;
            r_drop       <= 16'd0;
            r_soft_reset <= 1'b1;
        end else begin
            r_soft_reset <= 1'b0;
            if (r_stb && !bus.i_busy) begin
                r_stb <= 1'b0;
            end
            if (w_accept) begin
                if (w_ctrl_c) begin
                    r_cnt        <= '0;
                    r_acc        <= '0;
                    r_soft_reset <= 1'b1;
                end else if (w_legal) begin
                    r_acc <= w_acc_next;
                    if (r_cnt == LAST_CNT) begin
                        r_stb   <= 1'b1;
                        r_valid <= 1'b1;
                        r_data  <= w_acc_next;
                        r_raw   <= 8'd0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end else begin
                    r_stb   <= 1'b1;
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_raw   <= bus.i_byte;
                    if (r_cnt != '0 && r_drop != 16'hFFFF) begin
                        r_drop <= r_drop + 16'd1;
                    end
                    r_cnt <= '0;
                    r_acc <= '0;
                end
            end
        end
    end

    assign bus.o_busy       = r_stb && bus.i_busy;
    assign bus.o_stb        = r_stb;
    assign bus.o_valid      = r_valid;
    assign bus.o_data       = r_data;
    assign bus.o_raw        = r_raw;
    assign bus.o_drop       = r_drop;
    assign bus.o_soft_reset = r_soft_reset;
endmodule

// File: tb/tb_wbutohex_pack.sv
// Directed bench for wbutohex_pack across several MODE/PACK configurations.
module tb_wbutohex_pack;
    logic       clk;
    logic       tb_reset;
    logic       tb_stb;
    logic [7:0] tb_byte;
    logic       tb_busy;
    logic [2:0] tb_sel;
    int         n_tests;
    int         n_fail;

    wbutohex_pack_if #(.DW(6))  if_a ();
    wbutohex_pack_if #(.DW(8))  if_b ();
    wbutohex_pack_if #(.DW(24)) if_c ();
    wbutohex_pack_if #(.DW(16)) if_d ();
    wbutohex_pack_if #(.DW(18)) if_e ();

    wbutohex_pack #(.MODE(0), .PACK(1)) u_a (.i_clk(clk), .i_reset(tb_reset), .bus(if_a));
    wbutohex_pack #(.MODE(1), .PACK(2)) u_b (.i_clk(clk), .i_reset(tb_reset), .bus(if_b));
    wbutohex_pack #(.MODE(0), .PACK(4)) u_c (.i_clk(clk), .i_reset(tb_reset), .bus(if_c));
    wbutohex_pack #(.MODE(1), .PACK(4)) u_d (.i_clk(clk), .i_reset(tb_reset), .bus(if_d));
    wbutohex_pack #(.MODE(0), .PACK(3)) u_e (.i_clk(clk), .i_reset(tb_reset), .bus(if_e));

    assign if_a.i_stb = tb_stb && (tb_sel == 3'd0);
    assign if_b.i_stb = tb_stb && (tb_sel == 3'd1);
    assign if_c.i_stb = tb_stb && (tb_sel == 3'd2);
    assign if_d.i_stb = tb_stb && (tb_sel == 3'd3);
    assign if_e.i_stb = tb_stb && (tb_sel == 3'd4);
    assign if_a.i_byte = tb_byte;
    assign if_b.i_byte = tb_byte;
    assign if_c.i_byte = tb_byte;
    assign if_d.i_byte = tb_byte;
    assign if_e.i_byte = tb_byte;
    assign if_a.i_busy = tb_busy;
    assign if_b.i_busy = tb_busy;
    assign if_c.i_busy = tb_busy;
    assign if_d.i_busy = tb_busy;
    assign if_e.i_busy = tb_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison point.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte to the selected DUT for one clock, sample #1 after the edge.
    task automatic send(input logic [2:0] sel, input logic [7:0] b);
        tb_sel  = sel;
        tb_byte = b;
        tb_stb  = 1'b1;
        @(posedge clk);
        #1;
        tb_stb  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        tb_reset = 1'b1;
        tb_stb   = 1'b0;
        tb_byte  = 8'd0;
        tb_busy  = 1'b0;
        tb_sel   = 3'd0;
        tick();
        tick();
        check("rst_soft", 32'(if_a.o_soft_reset), 32'd1);
        check("rst_stb", 32'(if_a.o_stb), 32'd0);
        check("rst_drop", 32'(if_d.o_drop), 32'd0);
        check("rst_data", 32'(if_c.o_data), 32'd0);
        tb_reset = 1'b0;
        check("rst_soft_after", 32'(if_a.o_soft_reset), 32'd1);
        tick();
        check("rst_soft_clear", 32'(if_a.o_soft_reset), 32'd0);

        // MODE 0, PACK 1: every symbol is a word
        send(3'd0, "A");
        check("a_stb0", 32'(if_a.o_stb), 32'd1);
        check("a_valid0", 32'(if_a.o_valid), 32'd1);
        check("a_data0", 32'(if_a.o_data), 32'd10);
        send(3'd0, "z");
        check("a_stb1", 32'(if_a.o_stb), 32'd1);
        check("a_data1", 32'(if_a.o_data), 32'd61);
        send(3'd0, "%");
        check("a_stb2", 32'(if_a.o_stb), 32'd1);
        check("a_data2", 32'(if_a.o_data), 32'd63);
        tick();
        check("a_stb_idle", 32'(if_a.o_stb), 32'd0);

        // MODE 1, PACK 2: hex pairs and an illegal letter
        send(3'd1, "3");
        check("b_mid_stb", 32'(if_b.o_stb), 32'd0);
        send(3'd1, "f");
        check("b_stb0", 32'(if_b.o_stb), 32'd1);
        check("b_data0", 32'(if_b.o_data), 32'h3F);
        send(3'd1, "A");
        check("b_stb_drop", 32'(if_b.o_stb), 32'd0);
        send(3'd1, "0");
        check("b_data1", 32'(if_b.o_data), 32'hA0);
        check("b_valid1", 32'(if_b.o_valid), 32'd1);
        send(3'd1, "G");
        check("b_stb_ill", 32'(if_b.o_stb), 32'd1);
        check("b_valid_ill", 32'(if_b.o_valid), 32'd0);
        check("b_raw_ill", 32'(if_b.o_raw), 32'h47);
        check("b_data_ill", 32'(if_b.o_data), 32'd0);
        check("b_drop_ill", 32'(if_b.o_drop), 32'd0);

        // MODE 0, PACK 4: output hold under downstream stall, stalled byte kept
        send(3'd2, "%");
        send(3'd2, "%");
        send(3'd2, "%");
        send(3'd2, "%");
        check("c_stb0", 32'(if_c.o_stb), 32'd1);
        check("c_data0", 32'(if_c.o_data), 32'hFFFFFF);
        tb_busy = 1'b1;
        tb_sel  = 3'd2;
        tb_byte = "1";
        tb_stb  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("c_hold_stb", 32'(if_c.o_stb), 32'd1);
            check("c_hold_data", 32'(if_c.o_data), 32'hFFFFFF);
            check("c_hold_busy", 32'(if_c.o_busy), 32'd1);
        end
        tb_busy = 1'b0;
        tick();
        tb_stb = 1'b0;
        check("c_release_stb", 32'(if_c.o_stb), 32'd0);
        send(3'd2, "2");
        send(3'd2, "3");
        send(3'd2, "4");
        check("c_stb1", 32'(if_c.o_stb), 32'd1);
        check("c_data1", 32'(if_c.o_data), 32'h0420C4);

        // MODE 1, PACK 4: partial word discarded by newline, then bit-7 byte
        send(3'd3, "1");
        send(3'd3, "2");
        send(3'd3, 8'h0A);
        check("d_nl_valid", 32'(if_d.o_valid), 32'd0);
        check("d_nl_raw", 32'(if_d.o_raw), 32'h0A);
        check("d_nl_drop", 32'(if_d.o_drop), 32'd1);
        send(3'd3, 8'hB1);
        check("d_b7_valid", 32'(if_d.o_valid), 32'd0);
        check("d_b7_raw", 32'(if_d.o_raw), 32'hB1);
        check("d_b7_drop", 32'(if_d.o_drop), 32'd1);

        // MODE 1, PACK 4 after reset: ^C discards quietly
        tb_reset = 1'b1;
        tick();
        tb_reset = 1'b0;
        tick();
        send(3'd3, "1");
        send(3'd3, "2");
        send(3'd3, 8'h03);
        check("e_soft_pulse", 32'(if_d.o_soft_reset), 32'd1);
        check("e_soft_stb", 32'(if_d.o_stb), 32'd0);
        send(3'd3, "a");
        check("e_soft_end", 32'(if_d.o_soft_reset), 32'd0);
        send(3'd3, "b");
        send(3'd3, "c");
        send(3'd3, "d");
        check("e_data", 32'(if_d.o_data), 32'hABCD);
        check("e_valid", 32'(if_d.o_valid), 32'd1);
        check("e_drop", 32'(if_d.o_drop), 32'd0);
        check("e_soft_quiet", 32'(if_d.o_soft_reset), 32'd0);

        // MODE 0, PACK 3: reset mid-word, byte offered during reset is lost
        send(3'd4, "x");
        send(3'd4, "y");
        tb_reset = 1'b1;
        tb_sel   = 3'd4;
        tb_byte  = "q";
        tb_stb   = 1'b1;
        tick();
        tb_stb   = 1'b0;
        check("f_rst_soft", 32'(if_e.o_soft_reset), 32'd1);
        check("f_rst_stb", 32'(if_e.o_stb), 32'd0);
        tb_reset = 1'b0;
        check("f_soft_after", 32'(if_e.o_soft_reset), 32'd1);
        send(3'd4, "x");
        check("f_soft_clear", 32'(if_e.o_soft_reset), 32'd0);
        check("f_mid_stb", 32'(if_e.o_stb), 32'd0);
        send(3'd4, "y");
        send(3'd4, "z");
        check("f_stb", 32'(if_e.o_stb), 32'd1);
        check("f_data", 32'(if_e.o_data), 32'h3BF3D);
        check("f_drop", 32'(if_e.o_drop), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wbutohex_pack.md
# wbutohex_pack

Parametrised ASCII-to-symbol decoder and packer for the wbubus command path. It sits between the serial receive byte stream and the command decompressor. Each printable byte is decoded to a 6-bit (wbu alphabet) or 4-bit (plain hex) symbol. PACK consecutive symbols are assembled into one output word, while framing characters, illegal bytes and soft resets (^C) are reported.

## Interface
- MODE, default 0: 0 selects the 6-bit wbu alphabet (BW=6); 1 selects the hex alphabet (BW=4).
- PACK, default 1: symbols per output word, legal range 1..8.
- DW, derived: PACK*BW, the output data width. It is not user-settable.
- i_clk  input  1  clock
- i_reset  input  1  reset i_reset, synchronous, active-high; clock i_clk
- i_stb  input  1  input byte valid
- o_busy  output  1  input stall; a byte is accepted when i_stb && !o_busy
- i_byte  input  8  received byte
- o_soft_reset  output  1  soft-reset indication to downstream logic
- o_stb  output  1  output word valid
- i_busy  input  1  downstream stall
- o_valid  output  1  1 = o_data holds a complete packed word; 0 = framing/illegal byte
- o_data  output  DW  packed symbols; the first-received symbol is in the MS BW bits
- o_raw  output  8  the byte that caused an o_valid=0 word
- o_drop  output  16  saturating count of partial words discarded

## Operation
- o_busy = o_stb && i_busy.
- Decode rules, applied to i_byte[6:0]:
  - In both modes, if i_byte[7] is set, the byte is illegal.
  - MODE 0: '0'-'9'→0-9, 'A'-'Z'→10-35, 'a'-'z'→36-61, '@'→62, '%'→63.
  - MODE 1: '0'-'9'→0-9, 'A'-'F' and 'a'-'f'→10-15. All other letters, '@' and '%' are illegal.
- State: accumulator acc[DW-1:0] and symbol count cnt (0..PACK-1).
- Accepted valid symbol:
  - acc <= {acc, sym} (left shift).
  - If cnt==PACK-1: emit a word (o_valid=1, o_data=new acc) and set cnt<=0. Otherwise cnt<=cnt+1 and nothing is emitted.
- Accepted ^C (i_byte[6:0]==7'h03, i_byte[7] ignored):
  - cnt<=0, acc<=0.
  - o_soft_reset pulses for one cycle.
  - No word is emitted and o_drop does not increment.
- Any other accepted byte (whitespace, newline, illegal):
  - Emit o_valid=0, o_raw=i_byte, o_data=0.
  - If cnt!=0, o_drop increments, saturating at 16'hFFFF.
  - cnt<=0, acc<=0.
- Output hold: while o_stb && i_busy, o_stb, o_valid, o_data and o_raw are held stable.
- Reset (i_reset, including mid-word): o_stb=0, cnt=0, acc=0, o_drop=0, o_valid=0, o_data=0, o_raw=0, o_soft_reset=1.

## Timing
- The registered output reflects a byte accepted at cycle t: o_stb, o_valid, o_data and o_raw update at t+1. Latency is one cycle.
- o_stb falls at the first edge where o_stb && !i_busy and no new emitting byte is accepted.
- Back-to-back words are emitted every cycle when i_busy=0. Throughput is one byte per clock.
- Non-emitting bytes (mid-word symbols, ^C) arriving while o_stb && !i_busy still cause o_stb to drop on the next edge.
- o_soft_reset:
  - Is 1 on every cycle with i_reset and on the first cycle after reset.
  - Afterwards it is 1 exactly on the cycle after a ^C is accepted, and 0 otherwise.
- o_drop updates one cycle after the discarding byte is accepted, together with the o_valid=0 word.
- Simultaneous i_reset and i_stb: reset wins and the byte is lost.

## Test plan
- MODE=0, PACK=1: bytes 'A','z','%' with i_busy=0 → o_stb on three consecutive cycles with o_data=10, 61, 63 and o_valid=1.
- MODE=1, PACK=2: "3f" then "A0" → two words, 8'h3F and 8'hA0. 'G' → o_valid=0, o_raw=8'h47.
- MODE=0, PACK=4: "%%%%" with i_busy held high for 5 cycles after the first word → o_data=24'hFFFFFF stable throughout, o_busy=1, and no byte is lost once i_busy releases.
- MODE=1, PACK=4: "12" then 8'h0A → one o_valid=0 word with o_raw=8'h0A and o_drop=1. Byte 8'hB1 (bit 7 set) → illegal, o_drop unchanged because cnt was 0.
- MODE=1, PACK=4: "12", then ^C, then "abcd" → o_soft_reset pulses once and the next word is 16'hABCD. o_drop stays 0.
- MODE=0, PACK=3: i_reset asserted after two symbols, then "xyz" → o_soft_reset=1 for the reset cycle(s) plus one cycle, o_drop=0, and one word {59,60,61}.
